// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store front end (mem_access_unit) and its
// lane alignment helper (lane_align).
//   DATA_W       : memory word width (fixed at 32, four byte lanes)
//   SZ_BYTE/HALF/WORD : req_size encodings (2'b11 is handled as a word)
//   state_e      : request sequencing states
// ---------------------------------------------------------------------------
package mem_access_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// ---------------------------------------------------------------------------
// lane_align
// Combinational little-endian lane logic for the load/store front end.
//   off_i      : byte offset within the word (addr[1:0])
//   size_i     : access size (byte / half / word, 2'b11 = word)
//   unsigned_i : zero-extend loads when 1, sign-extend when 0
//   old_i      : word currently held in memory
//   new_i      : right-justified store data
//   load_o     : extracted and extended load value
//   merge_o    : old word with the store lane replaced
// Halfwords select their lane with off_i[1] only; words ignore the offset.
// ---------------------------------------------------------------------------
module lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = old_i[{off_i, 3'b000} +: 8];
    assign half_lane = off_i[1] ? old_i[31:16] : old_i[15:0];

    always_comb begin
        load_o  = old_i;
        merge_o = new_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                merge_o = old_i;
                merge_o[{off_i, 3'b000} +: 8] = new_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                merge_o = old_i;
                if (off_i[1]) begin
                    merge_o[31:16] = new_i[15:0];
                end else begin
                    merge_o[15:0] = new_i[15:0];
                end
            end
            default: begin
                load_o  = old_i;
                merge_o = new_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store front end for a word-only data memory. Byte/half/word requests
// arrive on a valid/ready handshake; sub-word stores become read-modify-write
// sequences, loads return an extended value as a one-cycle response pulse.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata               : request fields, captured on acceptance
//   rsp_valid, rsp_rdata,
//   rsp_err                 : completion pulse, load data, misalign flag
//   dm_addr, dm_din, dm_wen : memory word index, write data, write enable
//   dm_dout                 : memory read data (combinational from dm_addr)
//
// Build option
//   MEM_ACCESS_MISALIGN_EXC_EN : when defined, misaligned halves/words skip
//   the memory and respond immediately with rsp_err=1. When undefined,
//   alignment is not checked and rsp_err is always 0.
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_wen,
    input  logic [DATA_W-1:0] dm_dout
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic                uns_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   merge_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic                dm_wen_q;

    logic [DATA_W-1:0]   load_d;
    logic [DATA_W-1:0]   merge_d;
    logic                misalign;

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    // req_size[1] covers both 2'b10 and the word alias 2'b11.
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    lane_align u_lane_align (
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .old_i      (dm_dout),
        .new_i      (wdata_q),
        .load_o     (load_d),
        .merge_o    (merge_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            dm_wen_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        // Stores and errors report zero data.
                        rdata_q <= '0;
                        if (misalign) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we && req_size[1]) begin
                            // Full-word store needs no read.
                            state_q  <= WR;
                            dm_wen_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        merge_q  <= merge_d;
                        state_q  <= WR;
                        dm_wen_q <= 1'b1;
                    end else begin
                        rdata_q     <= load_d;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WR: begin
                    dm_wen_q    <= 1'b0;
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_valid_q ? rdata_q : '0;
    assign rsp_err   = rsp_err_q;
    assign dm_addr   = addr_q[ADDR_W-1:2];
    assign dm_wen    = dm_wen_q;
    // Write data is only driven while the write strobe is up.
    assign dm_din    = dm_wen_q ? (size_q[1] ? wdata_q : merge_q) : '0;

endmodule
